screen_buffer: RTL and testbench

//  Parametrised framebuffer RAM with a CPU read/write port and a streaming scan-out port.
//  The scan-out port carries a valid/ready handshake and line/frame markers.
//  It sits between the CPU data bus (memory-mapped screen region) and the video timing/serialiser logic.
//  It is fully posedge-synchronous: CPU and scan reads are registered, with 1-cycle RAM latency.

---
 rtl/screen_buffer.sv | 211 +++++++++++++++++++++
 tb/tb_screen_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_buffer.sv
// Framebuffer RAM with a CPU read/write port and a valid/ready scan-out stream.
// Optional clear engine compiled in when CLEAR_EN is defined.
module screen_buffer #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 13,
    parameter int                WPL       = 32,
    parameter int                LINES     = 256,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    input  logic              scan_start,
    input  logic              scan_ready,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_eol,
    output logic              scan_eof,
    input  logic              clear_req,
    output logic              clear_busy
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam int                COL_W    = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(WPL * LINES - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(WPL - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

`ifdef CLEAR_EN
    logic              clear_busy_q, clear_busy_d;
    logic [ADDR_W-1:0] clear_cnt_q, clear_cnt_d;

    always_comb begin
        clear_busy_d = clear_busy_q;
        clear_cnt_d  = clear_cnt_q;
        if (clear_busy_q) begin
            clear_cnt_d = clear_cnt_q + ADDR_W'(1);
            if (clear_cnt_q == '1) clear_busy_d = 1'b0;
        end else if (clear_req) begin
            clear_busy_d = 1'b1;
            clear_cnt_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clear_busy_q <= 1'b0;
            clear_cnt_q  <= '0;
        end else begin
            clear_busy_q <= clear_busy_d;
            clear_cnt_q  <= clear_cnt_d;
        end
    end

    // The clear engine owns the write port; CPU writes are dropped while it runs.
    assign wr_en      = clear_busy_q | wren;
    assign wr_addr    = clear_busy_q ? clear_cnt_q : address;
    assign wr_data    = clear_busy_q ? CLEAR_VAL : data;
    assign clear_busy = clear_busy_q;
`else
    logic [DATA_W:0] unused_clear;
    assign unused_clear = {clear_req, CLEAR_VAL};
    assign wr_en        = wren;
    assign wr_addr      = address;
    assign wr_data      = data;
    assign clear_busy   = 1'b0;
`endif

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
    logic [DATA_W-1:0] scan_rd_q, scan_rd_d;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              rd_valid_q, rd_valid_d, rd_eol_q, rd_eol_d, rd_eof_q, rd_eof_d;
    logic              out_valid_q, out_valid_d, out_eol_q, out_eol_d, out_eof_q, out_eof_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d, skid_eol_q, skid_eol_d, skid_eof_q, skid_eof_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              pop, issue;
    logic [1:0]        level;

    // Both read ports are write-first against the single write port.
    always_comb begin
        cpu_rd_d  = (wr_en && wr_addr == address) ? wr_data : mem[address];
        scan_rd_d = (wr_en && wr_addr == ptr_q) ? wr_data : mem[ptr_q];
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        scan_rd_q <= scan_rd_d;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        col_d        = col_q;
        rd_valid_d   = 1'b0;
        rd_eol_d     = rd_eol_q;
        rd_eof_d     = rd_eof_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_eol_d    = out_eol_q;
        out_eof_d    = out_eof_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_eol_d   = skid_eol_q;
        skid_eof_d   = skid_eof_q;
        pop          = out_valid_q & scan_ready;
        // Words the buffer will hold once the read now in flight lands.
        level        = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_valid_q) - 2'(pop);
        issue        = (state_q == S_STREAM) && !scan_start && (level < 2'd2);

        if (scan_start) begin
            state_d      = S_STREAM;
            ptr_d        = '0;
            col_d        = '0;
            out_valid_d  = 1'b0;
            out_eol_d    = 1'b0;
            out_eof_d    = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (issue) begin
                rd_valid_d = 1'b1;
                rd_eol_d   = (col_q == LAST_COL);
                rd_eof_d   = (ptr_q == LAST_PTR);
                col_d      = (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
                if (ptr_q == LAST_PTR) begin
                    ptr_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            if (!out_valid_q || pop) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = skid_data_q;
                    out_eol_d    = skid_eol_q;
                    out_eof_d    = skid_eof_q;
                    skid_valid_d = rd_valid_q;
                    skid_data_d  = scan_rd_q;
                    skid_eol_d   = rd_eol_q;
                    skid_eof_d   = rd_eof_q;
                end else begin
                    out_valid_d = rd_valid_q;
                    out_data_d  = rd_valid_q ? scan_rd_q : out_data_q;
                    out_eol_d   = rd_valid_q & rd_eol_q;
                    out_eof_d   = rd_valid_q & rd_eof_q;
                end
            end else if (rd_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = scan_rd_q;
                skid_eol_d   = rd_eol_q;
                skid_eof_d   = rd_eof_q;
            end
            if (state_q == S_DRAIN && !rd_valid_q && !skid_valid_q && (!out_valid_q || pop))
                state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rd_q     <= '0;
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            col_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_eol_q     <= 1'b0;
            rd_eof_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_eol_q   <= 1'b0;
            skid_eof_q   <= 1'b0;
        end else begin
            cpu_rd_q     <= cpu_rd_d;
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            col_q        <= col_d;
            rd_valid_q   <= rd_valid_d;
            rd_eol_q     <= rd_eol_d;
            rd_eof_q     <= rd_eof_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_eol_q   <= skid_eol_d;
            skid_eof_q   <= skid_eof_d;
        end
    end

    assign q          = cpu_rd_q;
    assign scan_valid = out_valid_q;
    assign scan_data  = out_data_q;
    assign scan_eol   = out_eol_q;
    assign scan_eof   = out_eof_q;
endmodule

// File: tb/tb_screen_buffer.sv
// Scoreboard bench for screen_buffer: frame words are queued at scan start and
// popped by a monitor on every accepted transfer. Define CLEAR_EN to test the clear engine.
module tb_screen_buffer;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 13;
    localparam int WPL    = 32;
    localparam int LINES  = 256;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int FRAME  = WPL * LINES;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data = '0;
    logic              wren = 1'b0;
    logic [DATA_W-1:0] q;
    logic              scan_start = 1'b0;
    logic              scan_ready = 1'b0;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;
    logic              scan_eol;
    logic              scan_eof;
    logic              clear_req = 1'b0;
    logic              clear_busy;

    screen_buffer dut (
        .clock(clock), .reset(reset), .address(address), .data(data), .wren(wren), .q(q),
        .scan_start(scan_start), .scan_ready(scan_ready), .scan_valid(scan_valid),
        .scan_data(scan_data), .scan_eol(scan_eol), .scan_eof(scan_eof),
        .clear_req(clear_req), .clear_busy(clear_busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              eol;
        logic              eof;
    } exp_t;

    exp_t              exp_q [$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, first_cyc = 0, last_cyc = 0, frame_rx = 0;
    int ready_pct = 100;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        scan_ready = ($urandom_range(99) < ready_pct);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected word per accepted transfer and checks stall stability.
    logic              hold_v = 1'b0;
    logic [DATA_W-1:0] hold_d;
    logic              hold_eol, hold_eof;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (!scan_valid || scan_data !== hold_d || scan_eol !== hold_eol || scan_eof !== hold_eof) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%0b d=%h eol=%0b eof=%0b, expected d=%h eol=%0b eof=%0b",
                             scan_valid, scan_data, scan_eol, scan_eof, hold_d, hold_eol, hold_eof);
                end
            end
            if (scan_valid && scan_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scan_extra: got word %h with no word expected", scan_data);
                end else begin
                    e = exp_q.pop_front();
                    if (scan_data !== e.d || scan_eol !== e.eol || scan_eof !== e.eof) begin
                        errors++;
                        $display("FAIL scan_word[%0d]: got d=%h eol=%0b eof=%0b, expected d=%h eol=%0b eof=%0b",
                                 frame_rx, scan_data, scan_eol, scan_eof, e.d, e.eol, e.eof);
                    end
                    if (frame_rx == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    frame_rx++;
                end
            end
            hold_v   = scan_valid && !scan_ready && !scan_start;
            hold_d   = scan_data;
            hold_eol = scan_eol;
            hold_eof = scan_eof;
        end
    end

    task automatic push_frame();
        for (int i = 0; i < FRAME; i++)
            exp_q.push_back('{d: ref_mem[i], eol: ((i % WPL) == WPL - 1), eof: (i == FRAME - 1)});
    endtask

    // Called at posedge+1; leaves at posedge+1 right after the edge that saw scan_start.
    task automatic start_scan(input bit check_leftover);
        scan_start = 1'b1;
        start_cyc  = cyc + 1;
        @(negedge clock);
        #1;
        if (check_leftover) chk("restart_leftover", exp_q.size(), 0);
        exp_q.delete();
        push_frame();
        frame_rx = 0;
        @(posedge clock);
        #1;
        scan_start = 1'b0;
        chk("valid_low_after_start", scan_valid, 0);
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        address = a;
        data    = d;
        wren    = 1'b1;
        ref_mem[a] = d;
        @(posedge clock);
        #1;
        wren = 1'b0;
    endtask

    task automatic cpu_check(input string name, input logic [ADDR_W-1:0] a);
        address = a;
        wren    = 1'b0;
        @(posedge clock);
        #1;
        chk(name, q, ref_mem[a]);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_rx(input string name, input int target, input int budget);
        int n = 0;
        while (frame_rx < target && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(name, (frame_rx >= target), 1);
    endtask

    task automatic check_idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            chk("idle_valid", scan_valid, 0);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_q", q, 0);
        chk("rst_valid", scan_valid, 0);
        chk("rst_data", scan_data, 0);
        chk("rst_eol", scan_eol, 0);
        chk("rst_eof", scan_eof, 0);
        chk("rst_busy", clear_busy, 0);
    endtask

    initial begin
        int n;
        logic [ADDR_W-1:0] a;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        @(posedge clock);
        #1;

        // CPU port: read-after-write, write-first on a same-cycle read, random pairs.
        cpu_write(13'h0010, 16'hA5A5);
        cpu_check("cpu_raw", 13'h0010);
        cpu_write(13'h0020, 16'h5555);
        cpu_write(13'h0020, 16'h1234);
        chk("cpu_write_first", q, 16'h1234);
        for (int i = 0; i < 8; i++) begin
            a = ADDR_W'($urandom_range(DEPTH - 1));
            cpu_write(a, DATA_W'($urandom));
            cpu_check("cpu_random", a);
        end
        $display("cpu port phase done: %0d checks", checks);

        for (int i = 0; i < DEPTH; i++) cpu_write(ADDR_W'(i), DATA_W'(i));
        $display("preload done");

        // Full frame, continuous ready.
        ready_pct = 100;
        @(posedge clock);
        #1;
        start_scan(1'b0);
        wait_empty("frame_ready1", FRAME + 100);
        chk("first_latency", first_cyc - start_cyc, 2);
        chk("frame_span", last_cyc - first_cyc, FRAME - 1);
        check_idle(5);
        $display("frame with continuous ready done: %0d words", frame_rx);

        // Random rewrites while idle, then a full frame under random ready.
        for (int i = 0; i < 40; i++) cpu_write(ADDR_W'($urandom_range(FRAME - 1)), DATA_W'($urandom));
        ready_pct = 50;
        start_scan(1'b0);
        wait_empty("frame_ready50", 4 * FRAME);
        chk("frame_count_ready50", frame_rx, FRAME);
        ready_pct = 100;
        check_idle(5);
        $display("frame with random ready done: %0d words", frame_rx);

        // Restart mid-frame at word 100, then restart on the final transfer.
        start_scan(1'b0);
        wait_rx("reach_word100", 100, 400);
        chk("word100_present", {scan_valid, scan_data}, {1'b1, ref_mem[100]});
        start_scan(1'b0);
        n = 0;
        while (!(scan_valid && scan_eof) && n < FRAME + 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("eof_presented", scan_valid && scan_eof, 1);
        chk("eof_frame_count", frame_rx, FRAME - 1);
        start_scan(1'b1);
        $display("restart phase done");

        // Reset mid-scan while a word is held valid.
        wait_rx("reach_word300", 300, 1000);
        ready_pct = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk("valid_before_reset", scan_valid, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_outputs();
        exp_q.delete();
        reset     = 1'b0;
        ready_pct = 100;
        check_idle(3);
        start_scan(1'b0);
        wait_rx("after_reset_words", 50, 200);
        ready_pct = 0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        exp_q.delete();
        reset     = 1'b0;
        ready_pct = 100;
        $display("reset phase done");

`ifdef CLEAR_EN
        clear_req = 1'b1;
        @(posedge clock);
        #1;
        clear_req = 1'b0;
        chk("clear_busy_rise", clear_busy, 1);
        n = 0;
        while (clear_busy && n < DEPTH + 50) begin
            n++;
            if (n == 5) begin
                address = 13'h0123;
                data    = 16'hBEEF;
                wren    = 1'b1;
                clear_req = 1'b1;
            end else begin
                wren      = 1'b0;
                clear_req = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        wren      = 1'b0;
        clear_req = 1'b0;
        chk("clear_busy_cycles", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        cpu_check("clear_dropped_write", 13'h0123);
        cpu_check("clear_first", '0);
        cpu_check("clear_last", '1);
        for (int i = 0; i < 100; i++) cpu_check("clear_random", ADDR_W'($urandom_range(DEPTH - 1)));
        $display("clear engine phase done");
`else
        clear_req = 1'b1;
        @(posedge clock);
        #1;
        clear_req = 1'b0;
        chk("clear_disabled_busy", clear_busy, 0);
        check_idle(1);
        chk("clear_disabled_busy2", clear_busy, 0);
        cpu_check("clear_disabled_ram", 13'h0005);
        $display("clear disabled phase done");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
